serial_tx_arbiter: RTL and testbench

//   Shares one dual-speed UART transmitter (8N1, slow/fast bit rate) between NUM_REQ byte requesters.
//   - Round-robin grant with bounded bursts per grant.
//   - Per-requester speed select; speed changes are applied only while the transmitter is idle.
//   - Sits between client blocks and the transmitter's data/new_data/busy/speed/block ports.

---
 rtl/serial_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one dual-speed 8N1 UART transmitter between NUM_REQ byte requesters.
// Grants are held for bounded bursts; speed changes are only requested while the transmitter is idle.
module serial_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int REQ_IDX_SIZE   = 2,
  parameter int MAX_BURST      = 16,
  parameter int BURST_CTR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_speed,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  input  logic                 pause,
  output logic [7:0]           tx_data,
  output logic                 tx_new_data,
  output logic                 tx_requested_speed,
  output logic                 tx_block,
  input  logic                 tx_busy,
  input  logic                 tx_current_speed
);

  // Handshake: a byte moves from requester i on the clock edge where req_valid[i] & req_ready[i];
  // req_ready is a one-cycle strobe coinciding with tx_new_data, so the requester holds its
  // valid/data/speed stable until it sees that strobe.

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SPEED      = 3'd1,
    SEND       = 3'd2,
    WAIT_START = 3'd3,
    WAIT_DONE  = 3'd4
  } state_t;

  localparam logic [REQ_IDX_SIZE-1:0]   LAST_RST  = REQ_IDX_SIZE'(NUM_REQ - 1);
  localparam logic [BURST_CTR_SIZE-1:0] BURST_LIM = BURST_CTR_SIZE'(MAX_BURST - 1);

  state_t                    state_q, state_d;
  logic [REQ_IDX_SIZE-1:0]   last_q, last_d;
  logic [REQ_IDX_SIZE-1:0]   g_q, g_d;
  logic [BURST_CTR_SIZE-1:0] burst_q, burst_d;
  logic                      spd_q, spd_d;
  logic [NUM_REQ-1:0]        grant_d;
  logic [NUM_REQ-1:0]        ready_d;
  logic                      new_d;
  logic [7:0]                data_d;
  logic                      rspd_d;

  logic                      pick_found;
  logic [REQ_IDX_SIZE-1:0]   pick_idx;
  int unsigned               cand;
  logic                      issue_en;
  logic [REQ_IDX_SIZE-1:0]   issue_idx;

  // Search downward over the rotation offset so the nearest requester after last wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = REQ_IDX_SIZE'(cand);
      end
    end
  end

  // The strobe is registered, so it is decided on the edge that enters (or stays in) SEND and
  // is high only while the FSM sits in SEND.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    g_d       = g_q;
    burst_d   = burst_q;
    spd_d     = spd_q;
    grant_d   = grant;
    rspd_d    = tx_requested_speed;
    issue_en  = 1'b0;
    issue_idx = g_q;
    case (state_q)
      IDLE: begin
        if (!pause && pick_found) begin
          g_d     = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
          burst_d = '0;
          spd_d   = req_speed[pick_idx];
          if (req_speed[pick_idx] != tx_current_speed) begin
            state_d = SPEED;
            rspd_d  = req_speed[pick_idx];
          end else begin
            state_d   = SEND;
            issue_en  = !tx_busy;
            issue_idx = pick_idx;
          end
        end
      end
      SPEED: begin
        if (tx_current_speed == spd_q && !tx_busy) begin
          state_d  = SEND;
          issue_en = req_valid[g_q] && !pause;
        end
      end
      SEND: begin
        if (tx_new_data) begin
          state_d = WAIT_START;
        end else if (!req_valid[g_q]) begin
          state_d = IDLE;
          last_d  = g_q;
          grant_d = '0;
        end else begin
          issue_en = !tx_busy && !pause;
        end
      end
      WAIT_START: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (burst_q < BURST_LIM && req_valid[g_q] && req_speed[g_q] == spd_q) begin
            burst_d  = burst_q + 1'b1;
            state_d  = SEND;
            issue_en = !pause;
          end else begin
            state_d = IDLE;
            last_d  = g_q;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    new_d   = issue_en;
    ready_d = issue_en ? (NUM_REQ'(1) << issue_idx) : '0;
    data_d  = issue_en ? req_data[int'(issue_idx)*8 +: 8] : tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      last_q             <= LAST_RST;
      g_q                <= '0;
      burst_q            <= '0;
      spd_q              <= 1'b0;
      grant              <= '0;
      req_ready          <= '0;
      tx_new_data        <= 1'b0;
      tx_data            <= '0;
      tx_requested_speed <= 1'b0;
      tx_block           <= 1'b0;
    end else begin
      state_q            <= state_d;
      last_q             <= last_d;
      g_q                <= g_d;
      burst_q            <= burst_d;
      spd_q              <= spd_d;
      grant              <= grant_d;
      req_ready          <= ready_d;
      tx_new_data        <= new_d;
      tx_data            <= data_d;
      tx_requested_speed <= rspd_d;
      tx_block           <= pause;
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: queue-fed requesters, a behavioural dual-speed transmitter,
// and a monitor that checks every strobe against a queue of hand-computed expected bytes.
module tb_serial_tx_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int SLOW_LEN = 12;
  localparam int FAST_LEN = 6;
  localparam int W        = 13;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_speed;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 pause;
  logic [7:0]           tx_data;
  logic                 tx_new_data;
  logic                 tx_requested_speed;
  logic                 tx_block;
  logic                 tx_busy;
  logic                 tx_current_speed;

  serial_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .REQ_IDX_SIZE(2), .MAX_BURST(16), .BURST_CTR_SIZE(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_speed(req_speed),
    .req_ready(req_ready), .grant(grant), .pause(pause),
    .tx_data(tx_data), .tx_new_data(tx_new_data),
    .tx_requested_speed(tx_requested_speed), .tx_block(tx_block),
    .tx_busy(tx_busy), .tx_current_speed(tx_current_speed)
  );

  // expected item: {grant one-hot, requested speed, data}
  logic [W-1:0] exp_q[$];
  logic [8:0]   src_q[NUM_REQ][$];
  int checks;
  int failures;
  int strobe_cnt;
  int want;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int r, input logic sp, input logic [7:0] d);
    logic [NUM_REQ-1:0] g;
    g = NUM_REQ'(1) << r;
    exp_q.push_back({g, sp, d});
  endtask

  task automatic wait_strobes(input int target);
    int n;
    n = 0;
    while (strobe_cnt < target && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    check("strobe_count", strobe_cnt, target);
  endtask

  task automatic wait_grant_zero();
    int n;
    n = 0;
    while (grant != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("grant_released", grant, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_grant", grant, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_new_data", tx_new_data, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_req_speed", tx_requested_speed, 0);
    check("rst_tx_block", tx_block, 0);
  endtask

  // requester drivers: present queue head, pop it after the accepting edge
  initial begin
    logic [NUM_REQ-1:0] taken;
    req_valid = '0;
    req_data  = '0;
    req_speed = '0;
    forever begin
      @(negedge clk);
      taken = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (taken[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = src_q[i][0][7:0];
          req_speed[i]       = src_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // transmitter model: busy from the cycle after the strobe, speed changes only while idle
  initial begin
    int busy_cnt;
    logic nd_s, rs_s;
    busy_cnt = 0;
    tx_busy = 1'b0;
    tx_current_speed = 1'b0;
    forever begin
      @(negedge clk);
      nd_s = tx_new_data;
      rs_s = tx_requested_speed;
      @(posedge clk); #1;
      if (busy_cnt > 0) busy_cnt--;
      if (nd_s === 1'b1) busy_cnt = tx_current_speed ? FAST_LEN : SLOW_LEN;
      else if (busy_cnt == 0 && rs_s === ~tx_current_speed) tx_current_speed = rs_s;
      tx_busy = (busy_cnt != 0);
    end
  end

  // monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    logic prev_rs;
    prev_rs = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (tx_new_data === 1'b1 || req_ready != 0) begin
          strobe_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", {grant, tx_requested_speed, tx_data}, 0);
          end else begin
            e = exp_q.pop_front();
            check("strobe_item", {grant, tx_requested_speed, tx_data}, e);
            check("ready_with_strobe", {tx_new_data, req_ready}, {1'b1, e[W-1:9]});
            check("speed_applied", tx_current_speed, e[8]);
          end
        end
        if (tx_requested_speed !== prev_rs) check("speed_change_idle", tx_busy, 0);
      end
      prev_rs = tx_requested_speed;
    end
  end

  initial begin
    int snap;
    int n;
    checks = 0;
    failures = 0;
    strobe_cnt = 0;
    want = 0;
    rst_n = 1'b0;
    pause = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single byte
    src_q[0].push_back({1'b0, 8'hA5});
    push_exp(0, 1'b0, 8'hA5);
    want += 1;
    wait_strobes(want);
    n = 0;
    while (!tx_busy && n < 100) begin @(negedge clk); n++; end
    check("grant_held_busy", grant, 4'b0001);
    wait_grant_zero();

    // round robin: last=0, so service order is 1,2,3,0
    for (int i = 0; i < NUM_REQ; i++) src_q[i].push_back({1'b0, 8'(8'h10 + i)});
    push_exp(1, 1'b0, 8'h11);
    push_exp(2, 1'b0, 8'h12);
    push_exp(3, 1'b0, 8'h13);
    push_exp(0, 1'b0, 8'h10);
    want += 4;
    wait_strobes(want);
    wait_grant_zero();

    // burst cap: 16 from req 2, then req 1, then req 2 resumes
    for (int k = 0; k < 20; k++) src_q[2].push_back({1'b0, 8'(8'h40 + k)});
    for (int k = 0; k < 16; k++) push_exp(2, 1'b0, 8'(8'h40 + k));
    push_exp(1, 1'b0, 8'hB0);
    push_exp(1, 1'b0, 8'hB1);
    for (int k = 16; k < 20; k++) push_exp(2, 1'b0, 8'(8'h40 + k));
    wait_strobes(want + 1);
    src_q[1].push_back({1'b0, 8'hB0});
    src_q[1].push_back({1'b0, 8'hB1});
    want += 22;
    wait_strobes(want);
    wait_grant_zero();

    // speed switch: req 0 slow then req 1 fast
    src_q[0].push_back({1'b0, 8'h11});
    src_q[1].push_back({1'b1, 8'h22});
    push_exp(0, 1'b0, 8'h11);
    push_exp(1, 1'b1, 8'h22);
    want += 2;
    wait_strobes(want);
    check("fast_applied", tx_current_speed, 1);
    wait_grant_zero();

    // pause mid-byte: byte completes, no new strobe until released
    src_q[2].push_back({1'b1, 8'h5A});
    src_q[2].push_back({1'b1, 8'h5B});
    push_exp(2, 1'b1, 8'h5A);
    push_exp(2, 1'b1, 8'h5B);
    want += 1;
    wait_strobes(want);
    @(posedge clk); #1;
    pause = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("tx_block_follows", tx_block, 1);
    snap = strobe_cnt;
    repeat (30) @(negedge clk);
    check("no_strobe_paused", strobe_cnt, snap);
    check("grant_held_paused", grant, 4'b0100);
    @(posedge clk); #1;
    pause = 1'b0;
    want += 1;
    wait_strobes(want);
    wait_grant_zero();

    // reset in WAIT_DONE: req 3 re-granted afterwards
    src_q[3].push_back({1'b0, 8'hC3});
    src_q[3].push_back({1'b0, 8'hC4});
    push_exp(3, 1'b0, 8'hC3);
    push_exp(3, 1'b0, 8'hC4);
    want += 1;
    wait_strobes(want);
    n = 0;
    while (!tx_busy && n < 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    check("regrant_after_reset", grant, 4'b1000);
    want += 1;
    wait_strobes(want);
    wait_grant_zero();

    repeat (5) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
